// File: rtl/posit_encoder_pp.sv
// Two-stage posit encoder on the rts/rtr decoded-posit stream, with a one-entry skid latch.
// Define POSIT_ENCODER_STATUS_EN to add the inexact_o / clamped_o status outputs. Requires POSIT_ES >= 1.
module posit_encoder_pp #(
    parameter int POSIT_WIDTH    = 8,
    parameter int POSIT_ES       = 1,
    parameter int SCALE_WIDTH    = 5,
    parameter int FRACTION_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rts_i,
    output logic                          rtr_o,
    input  logic                          sow_i,
    input  logic                          eow_i,
    input  logic                          sign_i,
    input  logic signed [SCALE_WIDTH-1:0] scale_i,
    input  logic [FRACTION_WIDTH-1:0]     fraction_i,
    input  logic                          guard_i,
    input  logic                          round_i,
    input  logic                          sticky_i,
    input  logic                          zero_i,
    input  logic                          NaR_i,
    output logic                          rts_o,
    input  logic                          rtr_i,
    output logic                          sow_o,
    output logic                          eow_o,
    output logic [POSIT_WIDTH-1:0]        posit_o
`ifdef POSIT_ENCODER_STATUS_EN
    ,
    output logic                          inexact_o,
    output logic                          clamped_o
`endif
);

    localparam int N     = POSIT_WIDTH;
    localparam int ES    = POSIT_ES;
    localparam int SW    = SCALE_WIDTH;
    localparam int FW    = FRACTION_WIDTH;
    localparam int EXT_W = N + ES + FW + 3;
    localparam logic signed [SW:0] MAXSCALE = (SW+1)'((N - 2) << ES);

    typedef struct packed {
        logic                 sow;
        logic                 eow;
        logic                 sign;
        logic                 zero;
        logic                 nar;
        logic signed [SW-1:0] scale;
        logic [FW-1:0]        frac;
        logic                 g;
        logic                 r;
        logic                 s;
    } pd_t;

    // Regime run then {e, fraction, GRS}, left-aligned; the N-2 pad bits keep sticky for any in-range k.
    function automatic logic [EXT_W-1:0] build_ext(input pd_t pd);
        logic signed [SW-1:0] k;
        logic [EXT_W-1:0]     base;
        int                   sh;
        k = $signed(pd.scale) >>> ES;
        if (!k[SW-1]) begin
            sh   = int'(k);
            base = {2'b10, pd.scale[ES-1:0], pd.frac, pd.g, pd.r, pd.s, {(N-2){1'b0}}};
        end else begin
            sh   = -int'(k) - 1;
            base = {2'b01, pd.scale[ES-1:0], pd.frac, pd.g, pd.r, pd.s, {(N-2){1'b0}}};
        end
        if (sh > N - 2) sh = N - 2;
        if (!k[SW-1]) return ~(~base >> sh);
        return base >> sh;
    endfunction

    // Round-to-nearest-even on the top N-1 bits; bit N-1 of the result is the carry out.
    function automatic logic [N-1:0] round_sum(input logic [EXT_W-1:0] ext);
        logic [N-2:0] m;
        logic         g;
        logic         s;
        m = ext[EXT_W-1 -: N-1];
        g = ext[EXT_W-N];
        s = |ext[EXT_W-N-1:0];
        return {1'b0, m} + N'(g & (s | m[0]));
    endfunction

    function automatic logic [N-2:0] sat_mag(input logic [N-1:0] sum);
        if (sum[N-1])          return {(N-1){1'b1}};
        if (sum[N-2:0] == '0)  return {{(N-2){1'b0}}, 1'b1};
        return sum[N-2:0];
    endfunction

    function automatic logic [N-1:0] sel_word(input logic sign, input logic zero, input logic nar,
                                              input logic hi, input logic lo, input logic [N-2:0] m);
        logic [N-1:0] w;
        if (nar)  return {1'b1, {(N-1){1'b0}}};
        if (zero) return '0;
        if (hi)      w = {1'b0, {(N-1){1'b1}}};
        else if (lo) w = {{(N-1){1'b0}}, 1'b1};
        else         w = {1'b0, m};
        return sign ? -w : w;
    endfunction

    logic             rtr_q, skid_vld_q, vld_p1_q, vld_p2_q;
    logic             process_en, accept;
    pd_t              in_pd, src_pd, skid_q;
    logic             hi_p1_d, lo_p1_d;
    logic [EXT_W-1:0] ext_p1_q;
    logic             sign_p1_q, zero_p1_q, nar_p1_q, hi_p1_q, lo_p1_q, sow_p1_q, eow_p1_q;
    logic [N-1:0]     sum_p2_d, word_p2_d, posit_p2_q;
    logic             sow_p2_q, eow_p2_q;

    assign process_en = rtr_i | ~vld_p2_q;
    assign accept     = rts_i & rtr_q;
    assign in_pd      = {sow_i, eow_i, sign_i, zero_i, NaR_i, scale_i, fraction_i, guard_i, round_i, sticky_i};
    assign src_pd     = skid_vld_q ? skid_q : in_pd;
    assign hi_p1_d    = $signed({src_pd.scale[SW-1], src_pd.scale}) > MAXSCALE;
    assign lo_p1_d    = $signed({src_pd.scale[SW-1], src_pd.scale}) < -MAXSCALE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtr_q      <= 1'b0;
            skid_vld_q <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
        end else begin
            rtr_q <= process_en;
            if (process_en) begin
                skid_vld_q <= 1'b0;
                vld_p1_q   <= skid_vld_q | accept;
                vld_p2_q   <= vld_p1_q;
            end else if (accept) begin
                skid_vld_q <= 1'b1;
            end
        end
    end

    // Stage 1: regime/exponent/fraction alignment and clamp detection
    always_ff @(posedge clk) begin
        if (!process_en && accept) skid_q <= in_pd;
        if (process_en && (skid_vld_q || accept)) begin
            ext_p1_q  <= build_ext(src_pd);
            sign_p1_q <= src_pd.sign;
            zero_p1_q <= src_pd.zero;
            nar_p1_q  <= src_pd.nar;
            hi_p1_q   <= hi_p1_d;
            lo_p1_q   <= lo_p1_d;
            sow_p1_q  <= src_pd.sow;
            eow_p1_q  <= src_pd.eow;
        end
    end

    // Stage 2: round, saturate, apply sign and specials
    assign sum_p2_d  = round_sum(ext_p1_q);
    assign word_p2_d = sel_word(sign_p1_q, zero_p1_q, nar_p1_q, hi_p1_q, lo_p1_q, sat_mag(sum_p2_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posit_p2_q <= '0;
            sow_p2_q   <= 1'b0;
            eow_p2_q   <= 1'b0;
        end else if (process_en && vld_p1_q) begin
            posit_p2_q <= word_p2_d;
            sow_p2_q   <= sow_p1_q;
            eow_p2_q   <= eow_p1_q;
        end
    end

`ifdef POSIT_ENCODER_STATUS_EN
    logic special_p2_d, clamped_p2_d, inexact_p2_d;
    logic inexact_p2_q, clamped_p2_q;

    assign special_p2_d = zero_p1_q | nar_p1_q;
    assign clamped_p2_d = ~special_p2_d & (hi_p1_q | lo_p1_q | sum_p2_d[N-1] | (sum_p2_d[N-2:0] == '0));
    assign inexact_p2_d = ~special_p2_d & ((|ext_p1_q[EXT_W-N:0]) | clamped_p2_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inexact_p2_q <= 1'b0;
            clamped_p2_q <= 1'b0;
        end else if (process_en && vld_p1_q) begin
            inexact_p2_q <= inexact_p2_d;
            clamped_p2_q <= clamped_p2_d;
        end
    end

    assign inexact_o = inexact_p2_q;
    assign clamped_o = clamped_p2_q;
`endif

    assign rtr_o   = rtr_q;
    assign rts_o   = vld_p2_q;
    assign sow_o   = sow_p2_q;
    assign eow_o   = eow_p2_q;
    assign posit_o = posit_p2_q;

endmodule

// File: tb/tb_posit_encoder_pp.sv
// Bench for posit_encoder_pp: directed vectors plus randomized traffic scored against a bit-queue posit model.
module tb_posit_encoder_pp;

    localparam int N     = 8;
    localparam int ES    = 1;
    localparam int SW    = 5;
    localparam int FW    = 4;
    localparam int MAXSC = (N - 2) << ES;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rts_i = 1'b0, rtr_o;
    logic                 sow_i = 1'b0, eow_i = 1'b0, sign_i = 1'b0;
    logic signed [SW-1:0] scale_i = '0;
    logic [FW-1:0]        fraction_i = '0;
    logic                 guard_i = 1'b0, round_i = 1'b0, sticky_i = 1'b0;
    logic                 zero_i = 1'b0, NaR_i = 1'b0;
    logic                 rts_o, rtr_i = 1'b1, sow_o, eow_o;
    logic [N-1:0]         posit_o;
`ifdef POSIT_ENCODER_STATUS_EN
    logic                 inexact_o, clamped_o;
`endif

    posit_encoder_pp #(
        .POSIT_WIDTH(N), .POSIT_ES(ES), .SCALE_WIDTH(SW), .FRACTION_WIDTH(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o),
        .sow_i(sow_i), .eow_i(eow_i), .sign_i(sign_i), .scale_i(scale_i),
        .fraction_i(fraction_i), .guard_i(guard_i), .round_i(round_i), .sticky_i(sticky_i),
        .zero_i(zero_i), .NaR_i(NaR_i), .rts_o(rts_o), .rtr_i(rtr_i),
        .sow_o(sow_o), .eow_o(eow_o), .posit_o(posit_o)
`ifdef POSIT_ENCODER_STATUS_EN
        , .inexact_o(inexact_o), .clamped_o(clamped_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Posit value built as an explicit bit string: regime run, exponent, fraction, GRS.
    function automatic logic [9:0] ref_encode(input logic sg, input int sc, input logic [FW-1:0] fr,
                                              input logic g, input logic r, input logic s,
                                              input logic z, input logic n);
        bit q[$];
        int k, e, mag;
        int p = 1 << ES;
        bit gb, sb, cl, ix;
        cl = 1'b0;
        ix = 1'b0;
        if (n) return {2'b00, 8'h80};
        if (z) return 10'h000;
        if (sc > MAXSC) begin
            mag = (1 << (N - 1)) - 1; cl = 1'b1; ix = 1'b1;
        end else if (sc < -MAXSC) begin
            mag = 1; cl = 1'b1; ix = 1'b1;
        end else begin
            k = (sc >= 0) ? sc / p : -((-sc + p - 1) / p);
            e = sc - k * p;
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = ES - 1; i >= 0; i--) q.push_back(e[i]);
            for (int i = FW - 1; i >= 0; i--) q.push_back(fr[i]);
            q.push_back(g);
            q.push_back(r);
            q.push_back(s);
            while (q.size() < N + 1) q.push_back(1'b0);
            mag = 0;
            for (int i = 0; i < N - 1; i++) mag = mag * 2 + int'(q[i]);
            gb = q[N-1];
            sb = 1'b0;
            for (int i = N; i < q.size(); i++) sb = sb | q[i];
            ix = gb | sb;
            if (gb && (sb || (mag % 2 == 1))) mag++;
            if (mag > (1 << (N - 1)) - 1) begin mag = (1 << (N - 1)) - 1; cl = 1'b1; end
            if (mag == 0) begin mag = 1; cl = 1'b1; end
        end
        if (sg) mag = (1 << N) - mag;
        return {cl, ix, 8'(mag)};
    endfunction

    typedef struct {
        logic [N-1:0] posit;
        logic         sow;
        logic         eow;
        logic         clamped;
        logic         inexact;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] mon_r;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rts_o && rtr_i) begin
                check_val("out_has_expect", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("posit", posit_o, mon_e.posit);
                    check_val("sow", sow_o, mon_e.sow);
                    check_val("eow", eow_o, mon_e.eow);
`ifdef POSIT_ENCODER_STATUS_EN
                    check_val("clamped", clamped_o, mon_e.clamped);
                    check_val("inexact", inexact_o, mon_e.inexact);
`endif
                end
            end
            if (rts_i && rtr_o) begin
                mon_r = ref_encode(sign_i, int'(scale_i), fraction_i, guard_i, round_i, sticky_i,
                                   zero_i, NaR_i);
                mon_e.posit   = mon_r[7:0];
                mon_e.inexact = mon_r[8];
                mon_e.clamped = mon_r[9];
                mon_e.sow     = sow_i;
                mon_e.eow     = eow_i;
                exp_q.push_back(mon_e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input logic sg, input int sc, input logic [FW-1:0] fr, input logic g,
                        input logic r, input logic s, input logic z, input logic n,
                        input logic so, input logic eo);
        int cnt;
        sign_i = sg; scale_i = SW'(sc); fraction_i = fr;
        guard_i = g; round_i = r; sticky_i = s; zero_i = z; NaR_i = n;
        sow_i = so; eow_i = eo; rts_i = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!rtr_o && cnt < 100);
        check_val("accept_rtr", rtr_o, 1);
        @(posedge clk);
        #1;
        rts_i = 1'b0;
    endtask

    task automatic directed(input string tag, input logic sg, input int sc, input logic [FW-1:0] fr,
                            input logic g, input logic r, input logic s, input logic z,
                            input logic n, input logic [N-1:0] exp);
        send(sg, sc, fr, g, r, s, z, n, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_val(tag, posit_o, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send_random();
        int sc;
        sc = int'($urandom_range(0, 31)) - 16;
        send($urandom_range(0, 1) == 1, sc, FW'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        check_val("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    bit rnd_bp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rtr_o", rtr_o, 0);
        check_val("rst_rts_o", rts_o, 0);
        check_val("rst_sow_o", sow_o, 0);
        check_val("rst_eow_o", eow_o, 0);
        check_val("rst_posit_o", posit_o, 0);
        rst_n = 1'b1;
        #1;
        check_val("rtr_o_at_release", rtr_o, 0);
        @(posedge clk);
        #1;
        check_val("rtr_o_after_release", rtr_o, 1);

        // First datum: exact two-cycle latency
        send(1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_val("lat_edge0_rts", rts_o, 0);
        @(negedge clk);
        check_val("lat_cycle1_rts", rts_o, 0);
        @(negedge clk);
        check_val("lat_cycle2_rts", rts_o, 1);
        check_val("lat_one_posit", posit_o, 8'h40);
        @(posedge clk);
        #1;

        directed("neg_one", 1'b1, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC0);
        directed("scale1", 1'b0, 1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h50);
        directed("sat_p12", 1'b0, 12, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F);
        directed("sat_p13", 1'b0, 13, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F);
`ifdef POSIT_ENCODER_STATUS_EN
        check_val("sat_p13_clamped", clamped_o, 1);
`endif
        directed("sat_p15", 1'b0, 15, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F);
        directed("sat_m12", 1'b0, -12, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        directed("sat_m16", 1'b0, -16, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
        directed("sat_neg_p13", 1'b1, 13, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81);
        directed("tie_up_even", 1'b0, 0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42);
        directed("tie_stay_even", 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
        directed("above_half", 1'b0, 0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h41);
        directed("round_bit_sticky", 1'b0, 0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41);
        directed("nar_and_zero", 1'b1, 3, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
        directed("zero_only", 1'b1, 3, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        directed("nar_only", 1'b0, -5, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
        drain();

        // Backpressure: six-value window, rtr_i low across cycles 3-6
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(1'b0, i * 2 - 5, FW'(i + 3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         i == 0, i == 5);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check_val("bp_rtr_before_stall", rtr_o, 1);
                rtr_i = 1'b0;
                @(posedge clk);
                #1;
                check_val("bp_rtr_drop", rtr_o, 0);
                repeat (3) @(posedge clk);
                #1;
                rtr_i = 1'b1;
            end
        join
        drain();

        // Reset with two values in flight
        send(1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_rts_o", rts_o, 0);
        check_val("midrst_posit_o", posit_o, 0);
        check_val("midrst_rtr_o", rtr_o, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        directed("after_reset", 1'b0, 1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h58);
        drain();

        // Randomized traffic with random downstream stalls
        rnd_bp = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_random();
                end
                rnd_bp = 1'b0;
            end
            begin
                while (rnd_bp) begin
                    @(posedge clk);
                    #1;
                    rtr_i = ($urandom_range(0, 9) >= 3);
                end
                rtr_i = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
